// File: rtl/cfg_reg_loader.sv
// Purpose : writes an enabled shadow table into the config register bank, reads each entry back to verify it, and retries or flags mismatches.
// Latency : an enabled entry takes 4+READ_LAT cycles and each retry adds 2+READ_LAT; a disabled entry takes 2 cycles; DONE adds 1.
// Backpressure : none; the bank is assumed ready every cycle. Host table writes and start are ignored while busy.
// Ports   : clk/reset (async active-low); tbl_we/tbl_addr/tbl_data/tbl_en load the table in IDLE;
//           start/busy/done control a pass; error/err_addr/err_count report verify failures;
//           reg_write/reg_addr/reg_wdata/reg_rdata form the register bank port.
module cfg_reg_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int NUM_REGS  = 8,
  parameter int READ_LAT  = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_we,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              tbl_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [3:0]        err_count,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int LAT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_WRITE, S_READ, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_tbl [NUM_REGS];
  logic [NUM_REGS-1:0] r_en;
  logic [ADDR_W-1:0]   r_idx;
  logic [RETRY_W-1:0]  r_retry;
  logic [LAT_W-1:0]    r_lat;
  logic                r_error;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [3:0]          r_err_count;
  logic [ADDR_W-1:0]   r_reg_addr;
  logic [DATA_W-1:0]   r_reg_wdata;

  logic w_last, w_lat_end, w_mismatch, w_retry_ok, w_tbl_wr;

  assign w_last     = (r_idx == ADDR_W'(NUM_REGS - 1));
  assign w_lat_end  = (r_lat == LAT_W'(READ_LAT - 1));
  assign w_mismatch = (reg_rdata != r_tbl[r_idx]);
  assign w_retry_ok = (r_retry < RETRY_W'(MAX_RETRY));
  // Table is only writable while idle so a pass always sees a stable table.
  assign w_tbl_wr   = (r_state == S_IDLE) && tbl_we && (32'(tbl_addr) < NUM_REGS);

  assign error     = r_error;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    done      = 1'b0;
    reg_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_SCAN;
      end
      S_SCAN:  w_next = r_en[r_idx] ? S_WRITE : S_NEXT;
      S_WRITE: begin
        reg_write = 1'b1;
        w_next    = S_READ;
      end
      S_READ:  if (w_lat_end) w_next = S_CHECK;
      S_CHECK: w_next = (w_mismatch && w_retry_ok) ? S_WRITE : S_NEXT;
      S_NEXT:  w_next = w_last ? S_DONE : S_SCAN;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_tbl[i] <= '0;
    end else if (w_tbl_wr) begin
      r_tbl[tbl_addr] <= tbl_data;
      r_en[tbl_addr]  <= tbl_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_retry     <= '0;
      r_lat       <= '0;
      r_error     <= 1'b0;
      r_err_addr  <= '0;
      r_err_count <= '0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx       <= '0;
            r_retry     <= '0;
            r_error     <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
          end
        end
        S_SCAN: begin
          // Bank port is loaded on entry to WRITE and then held through READ
          // and any retries of the same entry.
          if (r_en[r_idx]) begin
            r_reg_addr  <= r_idx;
            r_reg_wdata <= r_tbl[r_idx];
          end
        end
        S_WRITE: r_lat <= '0;
        S_READ:  r_lat <= r_lat + LAT_W'(1);
        S_CHECK: begin
          if (w_mismatch) begin
            if (w_retry_ok) begin
              r_retry <= r_retry + RETRY_W'(1);
            end else begin
              r_error    <= 1'b1;
              r_err_addr <= r_idx;
              if (r_err_count != 4'hF) r_err_count <= r_err_count + 4'd1;
            end
          end
        end
        S_NEXT: begin
          r_retry <= '0;
          if (!w_last) r_idx <= r_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_reg_loader.sv
module tb_cfg_reg_loader;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          reset, tbl_we, tbl_en, start;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic          busy, done, error, reg_write;
  logic [AW-1:0] err_addr, reg_addr;
  logic [3:0]    err_count;
  logic [DW-1:0] reg_wdata, reg_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int n_unexp = 0;
  logic [AW+DW-1:0] exp_q [$];

  // bank model: 0 ideal, 1 address 2 always reads back zero, 2 corrupt one readback
  int fault_mode = 0;
  int corrupt_idx = -1;
  int wr_cnt = 0;
  logic corrupt_pend = 1'b0;
  logic [DW-1:0] mem [NR];

  always #5 clk = ~clk;

  cfg_reg_loader dut (
    .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_en(tbl_en), .start(start), .busy(busy), .done(done), .error(error),
    .err_addr(err_addr), .err_count(err_count), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // Registered read: data for the address presented in one cycle is valid the next.
  always @(posedge clk) begin
    if (reg_write === 1'b1) begin
      mem[reg_addr] <= reg_wdata;
      corrupt_pend  <= (fault_mode == 2) && (wr_cnt == corrupt_idx);
      wr_cnt        <= wr_cnt + 1;
    end else begin
      corrupt_pend  <= 1'b0;
    end
    if (fault_mode == 1 && reg_addr == AW'(2)) reg_rdata <= '0;
    else if (corrupt_pend)                     reg_rdata <= ~mem[reg_addr];
    else                                       reg_rdata <= mem[reg_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d, input logic e);
    tbl_we = 1'b1; tbl_addr = AW'(a); tbl_data = d; tbl_en = e;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic expect_wr(input int a, input logic [DW-1:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic check_err(input string tag, input logic e, input int a, input int c);
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_err_addr"}, 32'(err_addr), 32'(a));
    chk({tag, "_err_count"}, 32'(err_count), 32'(c));
  endtask

  // Starts a pass, scoreboards every bank write, and counts cycles from the
  // first busy cycle through the done cycle inclusive.
  task automatic run_pass(input string tag, input int exp_cyc, input bit disturb);
    int cyc;
    bit seen;
    logic [AW+DW-1:0] e;
    n_unexp = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      cyc++;
      if (reg_write === 1'b1) begin
        if (exp_q.size() == 0) n_unexp++;
        else begin
          e = exp_q.pop_front();
          chk({tag, "_wr"}, 32'({reg_addr, reg_wdata}), 32'(e));
        end
      end
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (disturb && cyc >= 3 && cyc <= 6) begin
          tbl_we = 1'b1; tbl_addr = AW'(3); tbl_data = 16'hFFFF; tbl_en = 1'b0;
          start = (cyc % 2 == 1);
        end else begin
          tbl_we = 1'b0; start = 1'b0;
        end
        @(negedge clk);
      end
    end
    tbl_we = 1'b0; start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'(1));
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_unexpected_wr"}, 32'(n_unexp), 32'(0));
    chk({tag, "_missing_wr"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'(0));
    chk({tag, "_done_after"}, 32'(done), 32'(0));
  endtask

  initial begin
    int extra_done;
    bit seen;
    reset = 1'b0; tbl_we = 1'b0; tbl_en = 1'b0; start = 1'b0;
    tbl_addr = '0; tbl_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({busy, done, error, err_addr, err_count, reg_write}), 32'(0));
    chk("rst_addr_data", 32'({reg_addr, reg_wdata}), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // 1: all entries enabled, ideal bank
    for (int i = 0; i < NR; i++) begin
      load(i, 16'hA5A0 + 16'(i), 1'b1);
      expect_wr(i, 16'hA5A0 + 16'(i));
    end
    run_pass("all_en", 41, 1'b0);
    check_err("all_en", 1'b0, 0, 0);

    // 2: only entry 5 enabled
    for (int i = 0; i < NR; i++) load(i, (i == 5) ? 16'hBEEF : 16'h0000, (i == 5));
    expect_wr(5, 16'hBEEF);
    run_pass("one_en", 20, 1'b0);
    check_err("one_en", 1'b0, 0, 0);

    // 3: address 2 never verifies; one initial write plus two retries
    fault_mode = 1;
    for (int i = 0; i < NR; i++) begin
      load(i, (i == 2) ? 16'h1234 : 16'h1000 + 16'(i), 1'b1);
      expect_wr(i, (i == 2) ? 16'h1234 : 16'h1000 + 16'(i));
      if (i == 2) begin
        expect_wr(2, 16'h1234);
        expect_wr(2, 16'h1234);
      end
    end
    run_pass("stuck2", 47, 1'b0);
    check_err("stuck2", 1'b1, 2, 1);

    // 4: only the first readback of the pass is corrupted; error state from 3 clears
    fault_mode = 2;
    corrupt_idx = wr_cnt;
    expect_wr(0, 16'h1000);
    expect_wr(0, 16'h1000);
    for (int i = 1; i < NR; i++) expect_wr(i, (i == 2) ? 16'h1234 : 16'h1000 + 16'(i));
    run_pass("retry1", 44, 1'b0);
    check_err("retry1", 1'b0, 0, 0);

    // 5: table writes and start pulses while busy are ignored
    fault_mode = 0;
    for (int i = 0; i < NR; i++) begin
      load(i, 16'h5500 + 16'(i), 1'b1);
      expect_wr(i, 16'h5500 + 16'(i));
    end
    run_pass("busy_dist", 41, 1'b1);
    extra_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) extra_done++;
      @(negedge clk);
    end
    chk("busy_dist_extra_done", 32'(extra_done), 32'(0));
    chk("busy_dist_idle", 32'(busy), 32'(0));
    for (int i = 0; i < NR; i++) expect_wr(i, 16'h5500 + 16'(i));
    run_pass("busy_dist_again", 41, 1'b0);

    // 6: reset during READ, then a pass over the cleared table
    for (int i = 0; i < NR; i++) load(i, (i == 0) ? 16'h7777 : 16'h0000, (i == 0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (reg_write === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("midrst_wr_seen", 32'(seen), 32'(1));
    chk("midrst_wr", 32'({reg_addr, reg_wdata}), 32'({AW'(0), 16'h7777}));
    @(negedge clk);
    chk("midrst_in_read", 32'({busy, reg_write}), 32'(2'b10));
    reset = 1'b0;
    #1;
    chk("midrst_outs", 32'({busy, done, error, err_addr, err_count, reg_write}), 32'(0));
    chk("midrst_addr_data", 32'({reg_addr, reg_wdata}), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_pass("empty", 17, 1'b0);
    check_err("empty", 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_reg_loader.md
Name: cfg_reg_loader

Overview:
- Initiator for the 8-entry, 16-bit configuration register bank.
- Holds a shadow table of address/data values loaded by the host.
- On start, the FSM writes every enabled entry into the register bank over its write/address/data port.
- After each write it reads the entry back and compares it with the table value.
- A mismatch is retried, then flagged with the failing address.
- Sits between the host/boot logic and the config register bank, and replaces hand-sequenced register writes.

Parameters:
- DATA_W, 16: register data width.
- ADDR_W, 3: register address width.
- NUM_REGS, 8: number of table entries (≤ 2**ADDR_W).
- READ_LAT, 1: clocks from address presented (reg_write=0) to reg_rdata valid; must be ≥ 1.
- MAX_RETRY, 2: extra write attempts per entry after the first mismatch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tbl_we  input  1  host table write strobe.
- tbl_addr  input  ADDR_W  table entry index.
- tbl_data  input  DATA_W  table entry value.
- tbl_en  input  1  enable bit stored with the entry.
- start  input  1  begin a load pass (level, sampled in IDLE).
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse at end of pass.
- error  output  1  sticky: some entry failed after all retries.
- err_addr  output  ADDR_W  index of the most recent failed entry.
- err_count  output  4  failed entries this pass, saturating at 15.
- reg_write  output  1  write strobe to the register bank.
- reg_addr  output  ADDR_W  register address.
- reg_wdata  output  DATA_W  register write data.
- reg_rdata  input  DATA_W  register read data.

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0; FSM goes to IDLE.
  - Table data and enable bits clear to 0; idx, retry and latency counters clear to 0.
- Table writes:
  - In IDLE, tbl_we at a rising edge stores table[tbl_addr] and en[tbl_addr].
  - tbl_addr ≥ NUM_REGS is ignored.
  - tbl_we while busy=1 is ignored.
- start:
  - Accepted only in IDLE.
  - On acceptance: error, err_addr and err_count clear; idx=0; retry=0; busy=1; next state SCAN.
  - start while busy is ignored.
- States, one clock each unless noted:
  - IDLE: busy=0, reg_write=0.
  - SCAN: en[idx]=1 goes to WRITE; otherwise goes to NEXT.
  - WRITE: reg_write=1, reg_addr=idx, reg_wdata=table[idx] for exactly one cycle; goes to READ.
  - READ: reg_write=0, reg_addr held at idx; lasts READ_LAT cycles (latency counter); goes to CHECK.
  - CHECK: compares reg_rdata with table[idx], all DATA_W bits.
    - Match: goes to NEXT.
    - Mismatch and retry<MAX_RETRY: retry+1, goes to WRITE.
    - Mismatch and retry==MAX_RETRY: error=1, err_addr=idx, err_count+1 (saturating), goes to NEXT.
  - NEXT: retry=0.
    - idx==NUM_REGS-1: goes to DONE.
    - Otherwise idx+1, goes to SCAN.
  - DONE: done=1 for one cycle, busy=0 from the following cycle, goes to IDLE.
- Cycle costs:
  - Enabled entry that matches first time: 4+READ_LAT cycles.
  - Each retry adds 2+READ_LAT cycles.
  - Disabled entry: 2 cycles.
  - DONE: 1 cycle.
- Outside WRITE: reg_write=0 and reg_wdata holds its last value. reg_addr is driven only in WRITE and READ, and holds otherwise.
- error, err_addr and err_count hold after the pass until the next accepted start.
- No enabled entries: the pass completes in 2*NUM_REGS+1 cycles with no reg_write pulses.
- Reset mid-pass: immediate return to IDLE, table lost, no done pulse.
- idx does not wrap: exactly one pass per start.

Test Plan:
1. All 8 entries enabled, table[i]=16'hA5A0+i, ideal bank (READ_LAT=1) → 8 reg_write pulses at addresses 0..7 with the matching data; done rises 41 clocks after start is accepted; error=0, err_count=0.
2. Only entry 5 enabled with 16'hBEEF, others disabled → one write to address 3'b101 with 16'hBEEF; done after 7*2+5+1=20 clocks.
3. Bank model forces address 2 readback to 16'h0000, table[2]=16'h1234, MAX_RETRY=2 → three writes to address 2; error=1, err_addr=2, err_count=1; the remaining entries still written; done asserts.
4. Bank model corrupts the first readback only → two writes to that address, error=0.
5. tbl_we with new data and start pulses while busy → table and pass unchanged, one done pulse.
6. reset driven low mid-READ → outputs 0 within the same cycle (async), busy=0, table cleared; a subsequent start with an empty table gives no writes and done after 17 clocks.
